keypad_matrix_emulator: RTL and testbench



---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_matrix_emulator_bounce_lfsr.sv | 23 ++
 rtl/keypad_matrix_emulator.sv | 150 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix emulator: state encoding,
// idle row value and the key-code to matrix position mapping.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BOUNCE_P = 3'd1,
        HOLD     = 3'd2,
        BOUNCE_R = 3'd3,
        GAP      = 3'd4
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

    // Row pattern seen by the scanner: only the column of the pressed key matters
    function automatic logic [3:0] row_drive(input logic [3:0] key,
                                             input logic [3:0] col,
                                             input logic       closed);
        logic [3:0] r;
        r = ROW_IDLE;
        if (closed && !col[key_col(key)])
            r[key_row(key)] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies the contact
// bounce pattern; advances only while enabled, reloads its seed on reset.
module bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_out
);

    logic [15:0] q;

    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else if (en)
            q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    end

    assign bit_out = q[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 active-low matrix keypad: accepts a press request
// and plays press bounce, hold, release bounce and an inter-key gap.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          GAP_CYCLES    = 32,
    parameter int          HOLD_W        = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              busy,
    output logic              contact,
    output logic              done
);

    localparam int BOUNCE_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W0   = (HOLD_W > BOUNCE_W) ? HOLD_W : BOUNCE_W;
    localparam int CNT_W    = (CNT_W0 > GAP_W) ? CNT_W0 : GAP_W;

    localparam bit              NO_BOUNCE   = (BOUNCE_CYCLES == 0);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYCLES == 0) ? 1 : GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [3:0]        key_q, key_next;
    logic [HOLD_W-1:0] hold_q, hold_next;
    logic [HOLD_W-1:0] hold_req;
    logic              lfsr_en;
    logic              lfsr_bit;
    logic              last;

    bounce_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en     (lfsr_en),
        .bit_out(lfsr_bit)
    );

    // A zero hold request still produces one closed cycle
    assign hold_req = (req_hold == '0) ? HOLD_W'(1) : req_hold;
    assign last     = (cnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            key_q  <= '0;
            hold_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            key_q  <= key_next;
            hold_q <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        key_next   = key_q;
        hold_next  = hold_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        contact    = 1'b0;
        lfsr_en    = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    key_next  = req_key;
                    hold_next = hold_req;
                    if (NO_BOUNCE) begin
                        state_next = HOLD;
                        cnt_next   = CNT_W'(hold_req);
                    end else begin
                        state_next = BOUNCE_P;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end
            end
            BOUNCE_P: begin
                contact = lfsr_bit;
                lfsr_en = 1'b1;
                if (last) begin
                    state_next = HOLD;
                    cnt_next   = CNT_W'(hold_q);
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                contact = 1'b1;
                if (last) begin
                    if (NO_BOUNCE) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = BOUNCE_R;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            BOUNCE_R: begin
                contact = lfsr_bit;
                lfsr_en = 1'b1;
                if (last) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (last) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Purely combinational from col so the scanner sees a zero-latency switch
    assign row = row_drive(key_q, col, contact);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed self-checking bench: one emulator without bounce and one with the
// default 16-cycle bounce, driven through press, hold, gap and reset cases.
module tb_keypad_matrix_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a_col, a_row, a_key;
    logic        a_valid, a_ready, a_busy, a_contact, a_done;
    logic [15:0] a_hold;

    logic [3:0]  b_col, b_row, b_key;
    logic        b_valid, b_ready, b_busy, b_contact, b_done;
    logic [15:0] b_hold;

    int          checks = 0;
    int          errors = 0;
    int          n, m, rdy;
    logic [15:0] lfsr_m;
    logic        fb;

    keypad_matrix_emulator #(.BOUNCE_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .col(a_col), .row(a_row),
        .req_valid(a_valid), .req_ready(a_ready), .req_key(a_key), .req_hold(a_hold),
        .busy(a_busy), .contact(a_contact), .done(a_done)
    );

    keypad_matrix_emulator dut_b (
        .clk(clk), .rst(rst), .col(b_col), .row(b_row),
        .req_valid(b_valid), .req_ready(b_ready), .req_key(b_key), .req_hold(b_hold),
        .busy(b_busy), .contact(b_contact), .done(b_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit sel_b, input logic v, input logic [3:0] k,
                                 input logic [15:0] h);
        if (sel_b) begin
            b_valid = v; b_key = k; b_hold = h;
        end else begin
            a_valid = v; a_key = k; a_hold = h;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles until done rises, bounded so a stuck design still ends
    task automatic waitDoneA(output int cycles);
        cycles = 0;
        while (a_done !== 1'b1 && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        a_col = 4'hF; b_col = 4'hF;
        applyStimulus(0, 0, 4'd0, 16'd0);
        applyStimulus(1, 0, 4'd0, 16'd0);
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_row",     a_row,     4'hF);
        checkOutput("reset_ready",   a_ready,   1);
        checkOutput("reset_busy",    a_busy,    0);
        checkOutput("reset_done",    a_done,    0);
        checkOutput("reset_contact", a_contact, 0);
        checkOutput("reset_row_b",   b_row,     4'hF);

        $display("[TB] key 5 hold 100, no bounce");
        applyStimulus(0, 1, 4'd5, 16'd100);
        tick();
        applyStimulus(0, 0, 4'd0, 16'd0);
        a_col = 4'b1110; #1;
        checkOutput("k5_other_col", a_row, 4'b1111);
        a_col = 4'b0000; #1;
        checkOutput("k5_multi_low", a_row, 4'b1101);
        a_col = 4'b1101; #1;
        checkOutput("k5_row", a_row, 4'b1101);
        checkOutput("k5_busy", a_busy, 1);
        checkOutput("k5_ready", a_ready, 0);
        n = 0;
        while (a_row === 4'b1101 && n < 300) begin
            n++;
            tick();
        end
        checkOutput("k5_hold_len", n, 100);
        checkOutput("k5_gap_contact", a_contact, 0);
        waitDoneA(m);
        checkOutput("k5_gap_len", m, 31);
        tick();
        checkOutput("k5_done_pulse", a_done, 0);
        checkOutput("k5_idle_busy", a_busy, 0);
        checkOutput("k5_idle_ready", a_ready, 1);

        $display("[TB] key 15 hold 50 with bounce");
        b_col = 4'b0111;
        applyStimulus(1, 1, 4'd15, 16'd50);
        tick();
        applyStimulus(1, 0, 4'd0, 16'd0);
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("k15_press_bounce", b_row, lfsr_m[0] ? 4'b0111 : 4'b1111);
            fb = lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5];
            lfsr_m = (lfsr_m >> 1) | ({15'd0, fb} << 15);
            tick();
        end
        for (int i = 0; i < 50; i++) begin
            checkOutput("k15_hold", b_row, 4'b0111);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput("k15_release_bounce", b_row, lfsr_m[0] ? 4'b0111 : 4'b1111);
            fb = lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5];
            lfsr_m = (lfsr_m >> 1) | ({15'd0, fb} << 15);
            tick();
        end
        checkOutput("k15_gap_row", b_row, 4'hF);
        checkOutput("k15_gap_busy", b_busy, 1);
        m = 0;
        while (b_done !== 1'b1 && m < 200) begin
            m++;
            tick();
        end
        checkOutput("k15_gap_len", m, 31);
        tick();
        checkOutput("k15_idle_ready", b_ready, 1);

        $display("[TB] key 0 hold 0");
        a_col = 4'b1110;
        applyStimulus(0, 1, 4'd0, 16'd0);
        tick();
        applyStimulus(0, 0, 4'd0, 16'd0);
        n = 0;
        while (a_row === 4'b1110 && n < 300) begin
            n++;
            tick();
        end
        checkOutput("k0_hold_len", n, 1);
        waitDoneA(m);
        checkOutput("k0_gap_len", m, 31);
        tick();

        $display("[TB] back-to-back requests key 3 then key 9");
        applyStimulus(0, 1, 4'd3, 16'd5);
        tick();
        applyStimulus(0, 1, 4'd9, 16'd2);
        a_col = 4'b0111; #1;
        checkOutput("k3_row_after_key_change", a_row, 4'b1110);
        checkOutput("k3_ready_busy", a_ready, 0);
        rdy = 0; m = 0;
        while (a_done !== 1'b1 && m < 200) begin
            if (a_ready === 1'b1) rdy++;
            m++;
            tick();
        end
        checkOutput("k3_seq_len", m, 36);
        checkOutput("k3_ready_seen", rdy, 0);
        tick();
        checkOutput("k9_ready_after_done", a_ready, 1);
        checkOutput("k9_idle_busy", a_busy, 0);
        tick();
        applyStimulus(0, 0, 4'd0, 16'd0);
        checkOutput("k9_accepted_busy", a_busy, 1);
        a_col = 4'b1101; #1;
        checkOutput("k9_row", a_row, 4'b1011);
        waitDoneA(m);
        checkOutput("k9_seq_len", m, 33);
        tick();

        $display("[TB] reset during hold on key 6");
        a_col = 4'b1011;
        applyStimulus(0, 1, 4'd6, 16'd50);
        tick();
        applyStimulus(0, 0, 4'd0, 16'd0);
        tick(); tick(); tick();
        checkOutput("k6_row_hold", a_row, 4'b1101);
        rst = 1'b1;
        tick();
        checkOutput("k6_rst_row", a_row, 4'hF);
        checkOutput("k6_rst_busy", a_busy, 0);
        checkOutput("k6_rst_ready", a_ready, 1);
        checkOutput("k6_rst_done", a_done, 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (a_done === 1'b1) n++;
            tick();
        end
        checkOutput("k6_no_done_after_rst", n, 0);
        checkOutput("k6_idle_row", a_row, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
